// File: rtl/prog_mod_counter.sv
// Programmable modulus counter. It counts up or down, pauses on en, and can be
// cleared or preset. It produces a terminal-count tick and a square wave that
// toggles on each tick. A new modulus is taken from mod_in only at a wrap or a
// clear, so a period that has already started always runs to its end.
module prog_mod_counter #(
  parameter int          N         = 8,
  parameter int unsigned M_DEFAULT = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] mod_in,
  output logic [N-1:0] q,
  output logic         tick,
  output logic         sq_out,
  output logic         load_err,
  output logic [N-1:0] mod_cur
);

  localparam logic [N-1:0] M_INIT = N'(M_DEFAULT);

  logic [N-1:0] term;
  logic [N-1:0] wrap_val;
  logic         term_hit;

  // The last count of the period, the value to restart from after a wrap, and
  // whether q sits at the end that matches the current direction. A modulus of
  // 0 wraps to all ones here, which gives the full 2^N range.
  always_comb begin
    term     = mod_cur - N'(1);
    wrap_val = dir ? '0 : (mod_in - N'(1));
    term_hit = dir ? (q == term) : (q == '0);
    tick     = en & ~clr & ~load & ~reset & term_hit;
  end

  // Counter state update. Priority is reset, then clr, then load, then en.
  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      mod_cur  <= M_INIT;
      sq_out   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (clr) begin
        mod_cur <= mod_in;
        q       <= wrap_val;
        sq_out  <= 1'b0;
      end else if (load) begin
        if (load_val <= term) begin
          q <= load_val;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        if (term_hit) begin
          mod_cur <= mod_in;
          q       <= wrap_val;
          sq_out  <= ~sq_out;
        end else if (dir) begin
          q <= q + N'(1);
        end else begin
          q <= q - N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_mod_counter.sv
// Bench for prog_mod_counter. The stimulus process drives one vector per clock
// and queues what the DUT should show during that cycle. A separate monitor
// pops the queue on each falling edge and compares the DUT outputs with it.
module tb_prog_mod_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       dir;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] mod_in;
  logic [7:0] q;
  logic       tick;
  logic       sq_out;
  logic       load_err;
  logic [7:0] mod_cur;

  typedef struct packed {
    logic [7:0] q;
    logic       tick;
    logic       sq;
    logic       lerr;
    logic [7:0] modc;
  } exp_t;

  exp_t sb[$];
  int   n_vectors;
  int   n_miss;

  prog_mod_counter #(.N(8), .M_DEFAULT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .mod_in   (mod_in),
    .q        (q),
    .tick     (tick),
    .sq_out   (sq_out),
    .load_err (load_err),
    .mod_cur  (mod_cur)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge. The expected values
  // describe what the DUT presents during that same cycle.
  task automatic applyStimulus(input logic e, input logic d, input logic c,
                               input logic l, input logic [7:0] lv,
                               input logic [7:0] mi, input logic r,
                               input logic [7:0] xq, input logic xt,
                               input logic xs, input logic xe,
                               input logic [7:0] xm);
    exp_t x;
    @(posedge clk);
    #1;
    en = e; dir = d; clr = c; load = l; load_val = lv; mod_in = mi; reset = r;
    x.q = xq; x.tick = xt; x.sq = xs; x.lerr = xe; x.modc = xm;
    sb.push_back(x);
  endtask

  // A plain counting cycle with no clr, load or reset.
  task automatic countCycle(input logic d, input logic [7:0] mi,
                            input logic [7:0] xq, input logic xt,
                            input logic xs, input logic [7:0] xm);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 8'd0, mi, 1'b0, xq, xt, xs, 1'b0, xm);
  endtask

  // Compare the DUT outputs with one queued expectation.
  task automatic checkOutput(input exp_t x);
    n_vectors++;
    if ({q, tick, sq_out, load_err, mod_cur} !== x) begin
      n_miss++;
      $display("[TB] FAIL vec%0d: got q=%0d tick=%0b sq=%0b lerr=%0b mod=%0d, want q=%0d tick=%0b sq=%0b lerr=%0b mod=%0d",
               n_vectors, q, tick, sq_out, load_err, mod_cur,
               x.q, x.tick, x.sq, x.lerr, x.modc);
    end
  endtask

  // Monitor: check one queued vector on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  // Directed stimulus sequence.
  initial begin
    n_vectors = 0;
    n_miss    = 0;
    reset = 1'b1; en = 1'b0; dir = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = 8'd0; mod_in = 8'd10;
    repeat (2) @(posedge clk);

    $display("[TB] mod 10 up count, sq_out period 20");
    for (int i = 0; i < 40; i++)
      countCycle(1'b1, 8'd10, 8'(i % 10), (i % 10) == 9, 1'((i / 10) % 2), 8'd10);

    $display("[TB] modulus change mid-period");
    for (int i = 0; i < 4; i++)
      countCycle(1'b1, 8'd10, 8'(i), 1'b0, 1'b0, 8'd10);
    for (int i = 4; i < 10; i++)
      countCycle(1'b1, 8'd5, 8'(i), i == 9, 1'b0, 8'd10);
    for (int j = 0; j < 10; j++)
      countCycle(1'b1, 8'd5, 8'(j % 5), (j % 5) == 4, j < 5, 8'd5);

    $display("[TB] down count after clr to mod 6");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd6, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd5);
    for (int i = 0; i < 7; i++)
      countCycle(1'b0, 8'd6, (i == 6) ? 8'd5 : 8'(5 - i), i == 5, i == 6, 8'd6);

    $display("[TB] full range modulus 0, then modulus 1");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, 8'd6);
    for (int i = 0; i < 257; i++)
      countCycle(1'b1, 8'd0, 8'(i % 256), i == 255, i == 256, 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++)
      countCycle(1'b1, 8'd1, 8'd0, 1'b1, 1'(i % 2), 8'd1);

    $display("[TB] load, rejected load, clr beats load");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    countCycle(1'b1, 8'd10, 8'd0, 1'b0, 1'b0, 8'd10);
    countCycle(1'b1, 8'd10, 8'd1, 1'b0, 1'b0, 8'd10);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd3,  8'd10, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 8'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'd10, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 8'd10);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd12, 8'd10, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 8'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'd10, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 8'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'd10, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 8'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'd9,  8'd10, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 8'd10);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd2,  8'd10, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, 8'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'd10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd10);

    $display("[TB] en low at terminal, reset on a tick cycle");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd10);
    for (int i = 0; i < 4; i++)
      countCycle(1'b1, 8'd4, 8'(i), i == 3, 1'b0, 8'd4);
    for (int i = 0; i < 3; i++)
      countCycle(1'b1, 8'd4, 8'(i), 1'b0, 1'b1, 8'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 8'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 8'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd10);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      n_miss++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
    $finish;
  end

endmodule
